instruction_executor: RTL and testbench
=======================================

// Module: instruction_executor
// PURPOSE
//  Sequencer/ALU stage downstream of instruction_register. On start, walks read_pointer
//  from start_addr through count consecutive entries (wrapping 31->0), latches each iw,
//  executes opcode on op_a/op_b, and emits one result per instruction on a valid/ready port.
// PARAMETERS
//  DIV_CYCLES  32  iterations of the sequential divider (one quotient bit per cycle)
// PORTS
//  clk           in   1    clock, rising edge
//  rstN          in   1    reset, asynchronous, active-low
//  start         in   1    begin a run; sampled only in IDLE
//  start_addr    in   5    first entry to execute (address_t)
//  count         in   6    instructions in run, 1..32; 0 -> immediate done pulse
//  read_pointer  out  5    address into instruction_register (combinational read of iw)
//  iw            in   73   instruction_t read back from instruction_register
//  res           out  39   result_t {data[31:0], dbz, illegal, addr[4:0]}
//  res_valid     out  1    res holds a result
//  res_ready     in   1    consumer accepts res when res_valid && res_ready
//  busy          out  1    high in every state except IDLE
//  done          out  1    one-cycle pulse after last result accepted
// BEHAVIOUR
//  Reset: state=IDLE; read_pointer=0, res='0, res_valid=0, busy=0, done=0.
//  FSM: IDLE -start-> FETCH (count=0: IDLE, done=1 next cycle, no fetch).
//   FETCH: iw_q<=iw at read_pointer -> EXEC.
//   EXEC: ADD/SUB/MULT/SL/SR/illegal computed in one cycle -> RESP; DIV -> DIVIDE.
//   DIVIDE: DIV_CYCLES cycles in divider -> RESP. Divisor 0: skip divider, -> RESP next cycle.
//   RESP: res_valid=1, held stable until res_ready. On handshake: remaining-1;
//    remaining==0 -> IDLE, done=1 next cycle; else read_pointer+1 (mod 32) -> FETCH.
//  Latency FETCH->res_valid: 2 cycles non-DIV; 2+DIV_CYCLES for DIV.
//  Arithmetic (32-bit, op_type from iw_q):
//   ADD/SUB: modulo 2^32, no overflow flag. MULT: low 32 bits of product.
//   DIV: UNSIGNED u_data/u_data; SIGNED truncates toward zero, sign from operand signs.
//    Divisor 0 -> data=32'hFFFF_FFFF, dbz=1. SIGNED -2^31/-1 -> data=32'h8000_0000.
//   SL: op_a << op_b[4:0]. SR: logical if UNSIGNED, arithmetic if SIGNED; op_b[31:5] ignored.
//   opcode 6..15: data=0, illegal=1.
//  res.addr = entry address of the instruction producing the result.
//  start while busy: ignored. res_ready low: FSM stalls in RESP, no entry skipped/repeated.
//  rstN low mid-run (incl. DIVIDE): abort immediately to reset values; no done pulse.
// STRUCTURE
//  definitions_pkg gains: result_t (packed struct above), exec_state_t enum
//   {IDLE,FETCH,EXEC,DIVIDE,RESP}; reuses op_t, operand_type_t, data_t, instruction_t, address_t.
//  Sub-module seq_divider: unsigned restoring divider, start/busy/done, 32-bit dividend/divisor,
//   quotient out; executor handles sign fixup and divide-by-zero around it.
// TESTING
//  1 ADD SIGNED a=5,b=-7 at addr 3, start_addr=3,count=1 -> data=-2 (32'hFFFF_FFFE), addr=3, done.
//  2 DIV SIGNED a=-7,b=2 -> data=-3; UNSIGNED 7/0 -> data=32'hFFFF_FFFF, dbz=1, valid 1 cycle after EXEC.
//  3 SR a=32'h8000_0000,b=4: SIGNED -> 32'hF800_0000; UNSIGNED -> 32'h0800_0000; b=36 same as 4.
//  4 start_addr=30,count=4 -> results addr 30,31,0,1 in order; res_ready low 5 cycles -> res held.
//  5 opcode=4'hF -> data=0, illegal=1; MULT UNSIGNED 32'h1_0001*32'h1_0001 -> 32'h0002_0001.
//  6 rstN low 10 cycles into DIV -> all outputs reset; new start runs cleanly; count=0 -> done only.

Source files
------------

// File: rtl/definitions_pkg.sv
// Shared types for the instruction register / executor slice: instruction and result
// layouts, opcode and operand-type encodings, executor FSM states.
package definitions_pkg;

    typedef logic [31:0] data_t;
    typedef logic [4:0]  address_t;

    localparam int unsigned N_ENTRIES = 32;

    typedef enum logic [3:0] {
        ADD  = 4'h0,
        SUB  = 4'h1,
        MULT = 4'h2,
        DIV  = 4'h3,
        SL   = 4'h4,
        SR   = 4'h5
    } op_t;

    typedef enum logic {
        UNSIGNED = 1'b0,
        SIGNED   = 1'b1
    } operand_type_t;

    // rsvd carries instruction_register bookkeeping that the executor does not interpret
    typedef struct packed {
        op_t           opc;
        operand_type_t op_type;
        data_t         op_a;
        data_t         op_b;
        logic [3:0]    rsvd;
    } instruction_t;

    typedef struct packed {
        data_t    data;
        logic     dbz;
        logic     illegal;
        address_t addr;
    } result_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        EXEC   = 3'd2,
        DIVIDE = 3'd3,
        RESP   = 3'd4
    } exec_state_t;

    function automatic data_t abs32(input data_t v);
        return v[31] ? data_t'(-v) : v;
    endfunction

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle. done_o is high during the
// final iteration and quotient_o then already shows the completed quotient.
module seq_divider
    import definitions_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic  clk,
    input  logic  rstN,
    input  logic  start_i,
    input  data_t dividend_i,
    input  data_t divisor_i,
    output logic  busy_o,
    output logic  done_o,
    output data_t quotient_o
);

    localparam int CNT_W = $clog2(DIV_CYCLES + 1);

    data_t             rem_q, rem_d;
    data_t             quo_q, quo_d;
    data_t             dsr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              busy_q;

    logic [32:0]       rem_sh;
    logic              ge;

    always_comb begin
        rem_sh = {rem_q, quo_q[31]};
        ge     = (rem_sh >= {1'b0, dsr_q});
        rem_d  = ge ? data_t'(rem_sh - {1'b0, dsr_q}) : rem_sh[31:0];
        quo_d  = {quo_q[30:0], ge};
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dsr_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start_i) begin
            rem_q  <= '0;
            quo_q  <= dividend_i;
            dsr_q  <= divisor_i;
            cnt_q  <= CNT_W'(DIV_CYCLES);
            busy_q <= 1'b1;
        end else if (busy_q) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                busy_q <= 1'b0;
            end
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = busy_q && (cnt_q == CNT_W'(1));
    assign quotient_o = quo_d;

endmodule

// File: rtl/instruction_executor.sv
// Walks instruction_register entries from start_addr, executes each instruction and
// presents one result per entry on a valid/ready port; done pulses after the last one.
module instruction_executor
    import definitions_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic         clk,
    input  logic         rstN,
    input  logic         start,
    input  address_t     start_addr,
    input  logic [5:0]   count,
    output address_t     read_pointer,
    input  instruction_t iw,
    output result_t      res,
    output logic         res_valid,
    input  logic         res_ready,
    output logic         busy,
    output logic         done
);

    exec_state_t  state_q, state_d;
    address_t     rp_q, rp_d;
    logic [5:0]   remaining_q, remaining_d;
    instruction_t iw_q, iw_d;
    result_t      res_q, res_d;
    logic         done_q, done_d;
    logic         neg_q, neg_d;

    logic         div_start, div_busy, div_done;
    data_t        div_dividend, div_divisor, div_quotient;
    logic         is_signed;
    logic [4:0]   shamt;
    logic         unused_bits;

    assign is_signed    = (iw_q.op_type == SIGNED);
    assign shamt        = iw_q.op_b[4:0];
    assign div_dividend = is_signed ? abs32(iw_q.op_a) : iw_q.op_a;
    assign div_divisor  = is_signed ? abs32(iw_q.op_b) : iw_q.op_b;
    assign unused_bits  = ^{iw_q.rsvd, div_busy};

    seq_divider #(
        .DIV_CYCLES (DIV_CYCLES)
    ) u_div (
        .clk        (clk),
        .rstN       (rstN),
        .start_i    (div_start),
        .dividend_i (div_dividend),
        .divisor_i  (div_divisor),
        .busy_o     (div_busy),
        .done_o     (div_done),
        .quotient_o (div_quotient)
    );

    always_comb begin
        state_d     = state_q;
        rp_d        = rp_q;
        remaining_d = remaining_q;
        iw_d        = iw_q;
        res_d       = res_q;
        done_d      = 1'b0;
        neg_d       = neg_q;
        div_start   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (count == 6'd0) begin
                        done_d = 1'b1;
                    end else begin
                        rp_d        = start_addr;
                        remaining_d = count;
                        state_d     = FETCH;
                    end
                end
            end
            FETCH: begin
                iw_d    = iw;
                state_d = EXEC;
            end
            EXEC: begin
                res_d.addr    = rp_q;
                res_d.dbz     = 1'b0;
                res_d.illegal = 1'b0;
                res_d.data    = '0;
                state_d       = RESP;
                case (iw_q.opc)
                    ADD:  res_d.data = iw_q.op_a + iw_q.op_b;
                    SUB:  res_d.data = iw_q.op_a - iw_q.op_b;
                    MULT: res_d.data = iw_q.op_a * iw_q.op_b;
                    SL:   res_d.data = iw_q.op_a << shamt;
                    SR:   res_d.data = is_signed ? data_t'($signed(iw_q.op_a) >>> shamt)
                                                 : (iw_q.op_a >> shamt);
                    DIV: begin
                        if (iw_q.op_b == '0) begin
                            res_d.data = 32'hFFFF_FFFF;
                            res_d.dbz  = 1'b1;
                        end else begin
                            div_start = 1'b1;
                            neg_d     = is_signed && (iw_q.op_a[31] ^ iw_q.op_b[31]);
                            state_d   = DIVIDE;
                        end
                    end
                    default: res_d.illegal = 1'b1;
                endcase
            end
            DIVIDE: begin
                // Magnitude quotient from the divider; -2^31/-1 falls out as 32'h8000_0000
                if (div_done) begin
                    res_d.data = neg_q ? data_t'(-div_quotient) : div_quotient;
                    state_d    = RESP;
                end
            end
            RESP: begin
                if (res_ready) begin
                    remaining_d = remaining_q - 6'd1;
                    if (remaining_q == 6'd1) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        rp_d    = rp_q + 5'd1;
                        state_d = FETCH;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q     <= IDLE;
            rp_q        <= '0;
            remaining_q <= '0;
            iw_q        <= '0;
            res_q       <= '0;
            done_q      <= 1'b0;
            neg_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rp_q        <= rp_d;
            remaining_q <= remaining_d;
            iw_q        <= iw_d;
            res_q       <= res_d;
            done_q      <= done_d;
            neg_q       <= neg_d;
        end
    end

    assign read_pointer = rp_q;
    assign res          = res_q;
    assign res_valid    = (state_q == RESP);
    assign busy         = (state_q != IDLE);
    assign done         = done_q;

endmodule

// File: tb/tb_instruction_executor.sv
// Directed bench for instruction_executor: a model instruction_register array feeds iw,
// expected results are queued per run and compared as each result is handed off.
module tb_instruction_executor;
    import definitions_pkg::*;

    logic         clk = 1'b0;
    logic         rstN;
    logic         start;
    address_t     start_addr;
    logic [5:0]   count;
    address_t     read_pointer;
    instruction_t iw;
    result_t      res;
    logic         res_valid;
    logic         res_ready;
    logic         busy;
    logic         done;

    instruction_t mem [N_ENTRIES];
    result_t      exp_q [$];
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;

    assign iw = mem[read_pointer];

    instruction_executor #(
        .DIV_CYCLES (32)
    ) dut (
        .clk          (clk),
        .rstN         (rstN),
        .start        (start),
        .start_addr   (start_addr),
        .count        (count),
        .read_pointer (read_pointer),
        .iw           (iw),
        .res          (res),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .busy         (busy),
        .done         (done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic instruction_t mkins(input logic [3:0] opc, input logic ty,
                                           input data_t a, input data_t b);
        return {opc, ty, a, b, 4'h0};
    endfunction

    function automatic result_t mkres(input data_t d, input logic dbz, input logic ill,
                                      input address_t a);
        return {d, dbz, ill, a};
    endfunction

    task automatic start_run(input address_t sa, input logic [5:0] n);
        @(negedge clk);
        start_addr = sa;
        count      = n;
        start      = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // lat: expected cycles from FETCH to first res_valid (-1 = don't check)
    task automatic collect(input int n, input int lat, input int stall_idx);
        result_t exp;
        result_t held;
        int      w;
        for (int i = 0; i < n; i++) begin
            w = 0;
            do begin
                @(negedge clk);
                w++;
            end while (!res_valid && w < 200);
            chk("res_valid", res_valid, 1'b1);
            if (!res_valid) return;
            if (i == 0 && lat >= 0) chk("latency", w - 1, lat);
            exp = exp_q.pop_front();
            chk("res", res, exp);
            chk("busy_run", busy, 1'b1);
            if (i == stall_idx) begin
                held = res;
                repeat (5) begin
                    @(negedge clk);
                    chk("hold_valid", res_valid, 1'b1);
                    chk("hold_res", res, held);
                end
            end
            res_ready = 1'b1;
            @(posedge clk);
            #1 res_ready = 1'b0;
        end
        @(negedge clk);
        chk("done", done, 1'b1);
        chk("busy_end", busy, 1'b0);
        @(negedge clk);
        chk("done_pulse", done, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < N_ENTRIES; i++) mem[i] = mkins(4'h0, 1'b0, 32'd0, 32'd0);
        mem[3]  = mkins(4'h0, 1'b1, 32'd5, 32'hFFFF_FFF9);           // ADD S 5 + -7
        mem[10] = mkins(4'h3, 1'b1, 32'hFFFF_FFF9, 32'd2);           // DIV S -7 / 2
        mem[11] = mkins(4'h3, 1'b0, 32'd7, 32'd0);                   // DIV U 7 / 0
        mem[12] = mkins(4'h5, 1'b1, 32'h8000_0000, 32'd4);
        mem[13] = mkins(4'h5, 1'b0, 32'h8000_0000, 32'd4);
        mem[14] = mkins(4'h5, 1'b1, 32'h8000_0000, 32'd36);
        mem[15] = mkins(4'h5, 1'b0, 32'h8000_0000, 32'd36);
        mem[16] = mkins(4'h1, 1'b1, 32'd3, 32'd5);                   // SUB 3 - 5
        mem[17] = mkins(4'h4, 1'b0, 32'd1, 32'd35);                  // SL 1 << 3
        mem[18] = mkins(4'h3, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);   // -2^31 / -1
        mem[19] = mkins(4'h3, 1'b1, 32'd100, 32'hFFFF_FFF9);         // 100 / -7
        mem[20] = mkins(4'hF, 1'b0, 32'd9, 32'd9);                   // illegal
        mem[21] = mkins(4'h2, 1'b0, 32'h0001_0001, 32'h0001_0001);   // MULT U
        mem[22] = mkins(4'h3, 1'b0, 32'd100, 32'd7);
        mem[23] = mkins(4'h3, 1'b0, 32'hFFFF_FFFF, 32'd3);
        mem[24] = mkins(4'h6, 1'b1, 32'd1, 32'd1);                   // illegal
        mem[30] = mkins(4'h0, 1'b1, 32'h7FFF_FFFF, 32'd1);
        mem[31] = mkins(4'h2, 1'b1, 32'hFFFF_FFFD, 32'd4);           // -3 * 4
        mem[0]  = mkins(4'h1, 1'b0, 32'd0, 32'd1);
        mem[1]  = mkins(4'h4, 1'b0, 32'd1, 32'd31);

        rstN = 1'b0; start = 1'b0; start_addr = '0; count = '0; res_ready = 1'b0;
        #1;
        chk("rst_rp", read_pointer, 5'd0);
        chk("rst_res", res, 39'd0);
        chk("rst_valid", res_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        repeat (3) @(negedge clk);
        rstN = 1'b1;

        // signed add, single entry
        exp_q.push_back(mkres(32'hFFFF_FFFE, 1'b0, 1'b0, 5'd3));
        start_run(5'd3, 6'd1);
        collect(1, 2, -1);

        // signed divide through the divider, then divide-by-zero bypass
        exp_q.push_back(mkres(32'hFFFF_FFFD, 1'b0, 1'b0, 5'd10));
        start_run(5'd10, 6'd1);
        collect(1, 34, -1);
        exp_q.push_back(mkres(32'hFFFF_FFFF, 1'b1, 1'b0, 5'd11));
        start_run(5'd11, 6'd1);
        collect(1, 2, -1);

        // shifts, with shift amounts above 31 masked to 5 bits
        exp_q.push_back(mkres(32'hF800_0000, 1'b0, 1'b0, 5'd12));
        exp_q.push_back(mkres(32'h0800_0000, 1'b0, 1'b0, 5'd13));
        exp_q.push_back(mkres(32'hF800_0000, 1'b0, 1'b0, 5'd14));
        exp_q.push_back(mkres(32'h0800_0000, 1'b0, 1'b0, 5'd15));
        start_run(5'd12, 6'd4);
        collect(4, 2, -1);

        // mixed run including the signed-overflow divide corner
        exp_q.push_back(mkres(32'hFFFF_FFFE, 1'b0, 1'b0, 5'd16));
        exp_q.push_back(mkres(32'h0000_0008, 1'b0, 1'b0, 5'd17));
        exp_q.push_back(mkres(32'h8000_0000, 1'b0, 1'b0, 5'd18));
        exp_q.push_back(mkres(32'hFFFF_FFF2, 1'b0, 1'b0, 5'd19));
        start_run(5'd16, 6'd4);
        collect(4, 2, 2);

        // illegal opcodes, unsigned multiply, unsigned divide
        exp_q.push_back(mkres(32'h0000_0000, 1'b0, 1'b1, 5'd20));
        exp_q.push_back(mkres(32'h0002_0001, 1'b0, 1'b0, 5'd21));
        exp_q.push_back(mkres(32'd14,        1'b0, 1'b0, 5'd22));
        exp_q.push_back(mkres(32'h5555_5555, 1'b0, 1'b0, 5'd23));
        exp_q.push_back(mkres(32'h0000_0000, 1'b0, 1'b1, 5'd24));
        start_run(5'd20, 6'd5);
        collect(5, 2, -1);

        // wrap 31 -> 0 with back-pressure on the second result
        exp_q.push_back(mkres(32'h8000_0000, 1'b0, 1'b0, 5'd30));
        exp_q.push_back(mkres(32'hFFFF_FFF4, 1'b0, 1'b0, 5'd31));
        exp_q.push_back(mkres(32'hFFFF_FFFF, 1'b0, 1'b0, 5'd0));
        exp_q.push_back(mkres(32'h8000_0000, 1'b0, 1'b0, 5'd1));
        start_run(5'd30, 6'd4);
        collect(4, 2, 1);

        // asynchronous reset in the middle of a divide
        start_run(5'd22, 6'd1);
        repeat (10) @(posedge clk);
        #1;
        chk("pre_rst_busy", busy, 1'b1);
        chk("pre_rst_rp", read_pointer, 5'd22);
        rstN = 1'b0;
        #1;
        chk("mid_rst_rp", read_pointer, 5'd0);
        chk("mid_rst_res", res, 39'd0);
        chk("mid_rst_valid", res_valid, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_done", done, 1'b0);
        repeat (10) @(negedge clk);
        chk("rst_hold_done", done, 1'b0);
        rstN = 1'b1;

        exp_q.push_back(mkres(32'hFFFF_FFFE, 1'b0, 1'b0, 5'd3));
        start_run(5'd3, 6'd1);
        collect(1, 2, -1);

        // count = 0: done pulse only
        start_run(5'd7, 6'd0);
        @(negedge clk);
        chk("cnt0_done", done, 1'b1);
        chk("cnt0_busy", busy, 1'b0);
        chk("cnt0_valid", res_valid, 1'b0);
        @(negedge clk);
        chk("cnt0_done_pulse", done, 1'b0);
        chk("cnt0_rp", read_pointer, 5'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
